// File: rtl/clock_display_scan.sv
// Six-digit multiplexed h:m:s display: snapshots the time fields once per frame and
// turns each digit slot's field into BCD by repeated subtraction of ten before lighting it.
module clock_display_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] hour,
  input  logic [6:0] min,
  input  logic [6:0] sec,
  input  logic [2:0] blink_en,
  output logic [5:0] an_n,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic       frame_tick
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [CW-1:0] slot_cnt;
  logic [2:0]    idx, idx_nxt;
  logic [6:0]    snap_h, snap_m, snap_s, load_val, rem;
  logic [3:0]    tens, digit;
  logic [6:0]    pattern;
  logic          dash, slot_end, new_frame, field_blink, blanked, colon;
  logic [FW-1:0] frame_cnt;
  logic          frame_seen, blink_phase;

  always_comb begin
    slot_end  = (slot_cnt == SLOT_LAST);
    idx_nxt   = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    new_frame = slot_end && (idx_nxt == 3'd0);
    // idx 0 loads on the same edge the snapshot is captured, so it must read the live input
    case (idx_nxt)
      3'd0:       load_val = sec;
      3'd1:       load_val = snap_s;
      3'd2, 3'd3: load_val = snap_m;
      default:    load_val = snap_h;
    endcase
    case (idx[2:1])
      2'd0:    field_blink = blink_en[0];
      2'd1:    field_blink = blink_en[1];
      default: field_blink = blink_en[2];
    endcase
    blanked = blink_phase && field_blink;
    colon   = (idx == 3'd2) || (idx == 3'd4);
    digit   = idx[0] ? tens : rem[3:0];
    case (digit)
      4'd0:    pattern = 7'h40;
      4'd1:    pattern = 7'h79;
      4'd2:    pattern = 7'h24;
      4'd3:    pattern = 7'h30;
      4'd4:    pattern = 7'h19;
      4'd5:    pattern = 7'h12;
      4'd6:    pattern = 7'h02;
      4'd7:    pattern = 7'h78;
      4'd8:    pattern = 7'h00;
      4'd9:    pattern = 7'h10;
      default: pattern = 7'h7F;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt   <= SLOT_LAST;
      idx        <= 3'd5;
      rem        <= '0;
      tens       <= '0;
      dash       <= 1'b0;
      an_n       <= 6'h3F;
      seg_n      <= 7'h7F;
      dp_n       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= new_frame;
      if (slot_end) begin
        slot_cnt <= '0;
        idx      <= idx_nxt;
        rem      <= load_val;
        tens     <= '0;
        dash     <= (load_val >= 7'd100);
        an_n     <= 6'h3F;
        seg_n    <= 7'h7F;
        dp_n     <= 1'b1;
      end else begin
        slot_cnt <= slot_cnt + CW'(1);
        if (!dash && rem >= 7'd10) begin
          rem  <= rem - 7'd10;
          tens <= tens + 4'd1;
        end else begin
          // conversion settled: refresh every cycle so blink_en changes take effect live
          an_n  <= blanked ? 6'h3F : ~(6'd1 << idx);
          seg_n <= dash ? 7'h3F : pattern;
          dp_n  <= blanked || !colon;
        end
      end
    end
  end

  // Blink counts completed frames; the first snapshot after reset only opens frame 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_h      <= '0;
      snap_m      <= '0;
      snap_s      <= '0;
      frame_cnt   <= '0;
      frame_seen  <= 1'b0;
      blink_phase <= 1'b0;
    end else if (new_frame) begin
      snap_h     <= hour;
      snap_m     <= min;
      snap_s     <= sec;
      frame_seen <= 1'b1;
      if (frame_seen) begin
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_clock_display_scan.sv
// Randomized bench for clock_display_scan against a positional reference model.
`timescale 1ns/1ps
module tb_clock_display_scan;
  localparam int SD    = 16;
  localparam int BF    = 2;
  localparam int FRAME = 6 * SD;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] hour, min, sec;
  logic [2:0] blink_en;
  logic [5:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n, frame_tick;

  int n_chk  = 0;
  int n_pass = 0;
  int k      = 0;
  int snap[3];
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  always #5 clk = ~clk;

  clock_display_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .hour(hour), .min(min), .sec(sec),
    .blink_en(blink_en), .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n),
    .frame_tick(frame_tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s edge=%0d got=%0h expected=%0h", tag, k, got, exp);
  endtask

  // One clock edge; the model derives slot, digit and frame from the edge count since reset.
  task automatic step();
    int ix, e, n, v, showt;
    logic [2:0] be;
    logic disp, blank;
    logic [5:0] one, exp_an;
    logic [6:0] exp_seg;
    logic exp_dp;
    @(posedge clk);
    ix = (k / SD) % 6;
    e  = k % SD;
    n  = k / FRAME;
    if (ix == 0 && e == 0) begin
      snap[0] = int'(sec);
      snap[1] = int'(min);
      snap[2] = int'(hour);
    end
    be = blink_en;
    k++;
    @(negedge clk);
    v      = snap[ix / 2];
    showt  = (v >= 100) ? 1 : v / 10 + 1;
    disp   = (e >= showt);
    blank  = ((n / BF) % 2 == 1) && be[ix / 2];
    one    = 6'b1 << ix;
    exp_an = (disp && !blank) ? ~one : 6'h3F;
    if (!disp)         exp_seg = 7'h7F;
    else if (v >= 100) exp_seg = 7'h3F;
    else               exp_seg = seg_tab[(ix % 2 == 0) ? v % 10 : v / 10];
    exp_dp = !(disp && !blank && (ix == 2 || ix == 4));
    check("an_n", 32'(an_n), 32'(exp_an));
    check("seg_n", 32'(seg_n), 32'(exp_seg));
    check("dp_n", 32'(dp_n), 32'(exp_dp));
    check("frame_tick", 32'(frame_tick), 32'(ix == 0 && e == 0));
  endtask

  task automatic check_blank(input string tag);
    check({tag, "_an_n"}, 32'(an_n), 32'h3F);
    check({tag, "_seg_n"}, 32'(seg_n), 32'h7F);
    check({tag, "_dp_n"}, 32'(dp_n), 32'h1);
    check({tag, "_frame_tick"}, 32'(frame_tick), 32'h0);
  endtask

  initial begin
    rst = 1'b1; hour = '0; min = '0; sec = '0; blink_en = '0;
    repeat (3) @(negedge clk);
    check_blank("reset");
    rst = 1'b0;
    k = 0;

    hour = 7'd12; min = 7'd34; sec = 7'd56;
    repeat (2 * FRAME) step();

    // min changes after idx3 E5: the held snapshot must keep 34 until the next frame
    while ((k - 1) % FRAME != 3 * SD + 5) step();
    min = 7'd35;
    repeat (FRAME + 2 * SD) step();

    sec = 7'd59;
    repeat (2 * FRAME) step();

    hour = 7'd100; sec = 7'd0;
    repeat (2 * FRAME) step();

    for (int r = 0; r < 12; r++) begin
      hour     = 7'($urandom_range(0, 127));
      min      = 7'($urandom_range(0, 127));
      sec      = 7'($urandom_range(0, 99));
      blink_en = 3'($urandom_range(0, 7));
      repeat ($urandom_range(1, 2 * FRAME)) step();
    end

    // asynchronous reset while min tens is still converting
    hour = 7'd23; min = 7'd59; sec = 7'd0; blink_en = 3'b000;
    while ((k - 1) % FRAME != 3 * SD + 2) step();
    #2 rst = 1'b1;
    #1 check_blank("async_rst");
    @(negedge clk);
    check_blank("rst_held");
    rst = 1'b0;
    k = 0;
    blink_en = 3'b010;
    repeat (6 * FRAME) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/clock_display_scan.md
Name: clock_display_scan

Overview:
- Downstream consumer of the hour/minute/second counter outputs in the digital-clock datapath.
- Snapshots three 7-bit binary time fields once per frame and converts each to two BCD digits with a sequential subtract-10 converter.
- Time-multiplexes six common-anode 7-segment digits and blinks the field currently being set.

Parameters:
- SCAN_DIV, 50000, clk cycles per digit slot; legal range 16 or more.
- BLINK_FRAMES, 64, number of full 6-digit frames per blink-phase toggle; 1 or more.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- hour  input  7  binary hours (0-23 nominal)
- min  input  7  binary minutes (0-59)
- sec  input  7  binary seconds (0-59)
- blink_en  input  3  bit0=sec, bit1=min, bit2=hour; 1 = blink that field
- an_n  output  6  digit anodes, active-low, one-hot or all-high
- seg_n  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp_n  output  1  decimal point, active-low
- frame_tick  output  1  one-cycle pulse marking each snapshot

Behaviour:
Reset values:
- an_n=6'h3F, seg_n=7'h7F, dp_n=1, frame_tick=0, blink_phase=0, frame count=0.
- slot_cnt=SCAN_DIV-1, digit idx=5. No input snapshot is taken during reset.

Slot timing:
- slot_cnt counts 0..SCAN_DIV-1 and wraps.
- On wrap, idx advances 0..5 and wraps.
- The first edge after reset release is therefore slot start of idx 0.

Digit map:
- idx0 = sec ones (an_n[0]), idx1 = sec tens, idx2 = min ones, idx3 = min tens, idx4 = hour ones, idx5 = hour tens.

Snapshot:
- At the slot-start edge of idx 0, hour/min/sec are registered.
- frame_tick=1 for exactly the following cycle.
- Snapshot values are held for the whole frame; input changes mid-frame do not appear until the next frame.

Converter (per slot):
- At slot start (edge E0): rem is loaded with the selected field's snapshot, tens=0, and an_n/seg_n are forced blank (6'h3F / 7'h7F).
- Each later edge with rem>=10: rem-=10, tens+=1.
- The first edge with rem<10 sets done.
- Outputs drive from the edge after done is set, i.e. value v shows from edge E(floor(v/10)+1) until the end of the slot.
- Maximum latency is 10 edges, so SCAN_DIV>=16 guarantees display time.

Digit output:
- The ones slot shows rem and the tens slot shows tens. Both slots of a field run the full conversion.
- Patterns (active-low gfedcba) are standard:
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19
  - 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10
- A field with snapshot value >=100 shows dash (7'h3F) on both of its digits; the converter is skipped and outputs drive from E1.
- dp_n=0 while idx2 or idx4 is active and displayed (colon substitute); otherwise 1.

Blink:
- Frame counter increments at each snapshot.
- When it reaches BLINK_FRAMES-1 it clears and blink_phase toggles.
- While blink_phase=1 and the field's blink_en bit=1, that field's anodes stay high and dp_n stays 1. slot timing is unaffected.
- blink_en is sampled live each cycle.

Reset mid-operation:
- Immediate return to reset values; no partial digit is driven.

Invariants:
- At most one an_n bit low at any time.
- an_n is never low while conversion is in progress.

Test Plan:
1. SCAN_DIV=16, hour=12, min=34, sec=56 -> digits idx0..5 show 6,5,4,3,2,1 (seg_n 02,12,19,30,24,79). frame_tick every 96 cycles. dp_n low only on idx2 and idx4.
2. sec=59 held, check idx0 slot -> an_n=6'h3F for E0..E5; an_n=6'h3E and seg_n=7'h10 from E6 to slot end.
3. Change min from 34 to 35 during idx3 slot -> idx2/idx3 keep showing 4/3 for the rest of the frame; 5/3 appear next frame after frame_tick.
4. BLINK_FRAMES=2, blink_en=3'b010 -> frames 0-1 min digits lit, frames 2-3 an_n[2]/an_n[3] never low, frames 4-5 lit. Sec and hour digits are unaffected throughout.
5. hour=7'd100, sec=0 -> idx4/idx5 show 7'h3F from E1; idx0 and idx1 show 0 (7'h40) from E1.
6. Assert rst mid-conversion in idx3 -> an_n=6'h3F, seg_n=7'h7F, dp_n=1, frame_tick=0 immediately (asynchronous). After release, the next edge starts idx0 with a fresh snapshot and frame_tick.
